// File: rtl/rca_seq_pkg.sv
// Shared definitions for the sequential ripple-carry adder controller.
package rca_seq_pkg;

  // Width of the shared ripple-carry slice, in bits.
  localparam int SLICE_W = 4;

  // Controller states. The fourth encoding (2'd3) is never entered and
  // falls back to IDLE in the next-state logic.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of a counter that indexes nslice slice passes (never below 1 bit).
  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/rca4_slice.sv
// Purely combinational 4-bit ripple-carry adder made of four full-adder cells.
module rca4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    // Full-adder cell i: sum bit and carry to the next cell.
    assign s[i]       = a[i] ^ b[i] ^ c_s[i];
    assign c_s[i + 1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
  end

  assign cout = c_s[4];

endmodule

// File: rtl/rca_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder: one shared 4-bit slice is stepped LSB-first,
// one nibble per cycle, with the inter-nibble carry kept in a flop.
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDXW   = idx_width(NSLICE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
    $error("rca_seq_ctrl: WIDTH must be a positive multiple of 4");
  end

  state_t            state_r;
  state_t            state_nx_s;
  logic [IDXW-1:0]   idx_r;
  logic              carry_r;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic [WIDTH-1:0]  sum_r;
  logic              cout_r;
  logic              valid_r;

  logic              accept_s;
  logic              step_s;
  logic              last_s;
  logic              consume_s;

  logic [SLICE_W-1:0] slice_a_s;
  logic [SLICE_W-1:0] slice_b_s;
  logic [SLICE_W-1:0] slice_sum_s;
  logic               slice_cout_s;

  // Current nibble of each operand feeds the shared slice.
  assign slice_a_s = a_r[SLICE_W*idx_r +: SLICE_W];
  assign slice_b_s = b_r[SLICE_W*idx_r +: SLICE_W];

  rca4_slice u_slice (
    .a    (slice_a_s),
    .b    (slice_b_s),
    .cin  (carry_r),
    .s    (slice_sum_s),
    .cout (slice_cout_s)
  );

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    step_s     = 1'b0;
    last_s     = 1'b0;
    consume_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          accept_s   = 1'b1;
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        if (idx_r == LAST_IDX) begin
          last_s     = 1'b1;
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          consume_s  = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Operand capture, slice sequencing, carry flop and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      idx_r   <= '0;
      carry_r <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      if (accept_s) begin
        a_r     <= in_a;
        b_r     <= in_b;
        carry_r <= in_cin;
        idx_r   <= '0;
      end
      if (step_s) begin
        sum_r[SLICE_W*idx_r +: SLICE_W] <= slice_sum_s;
        carry_r                         <= slice_cout_s;
        idx_r                           <= idx_r + 1'b1;
      end
      if (last_s) begin
        cout_r  <= slice_cout_s;
        valid_r <= 1'b1;
      end
      if (consume_s) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign in_ready  = (state_r == ST_IDLE);
  assign busy      = (state_r == ST_RUN) || (state_r == ST_DONE);
  assign out_valid = valid_r;
  assign out_sum   = sum_r;
  assign out_cout  = cout_r;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Scoreboard bench for rca_seq_ctrl (WIDTH=16 main instance, WIDTH=8 side instance).
module tb_rca_seq_ctrl;

  localparam int W  = 16;
  localparam int NS = W / 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic [W-1:0]  in_a      = '0;
  logic [W-1:0]  in_b      = '0;
  logic          in_cin    = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          busy;

  logic          in_valid8  = 1'b0;
  logic [7:0]    in_a8      = '0;
  logic [7:0]    in_b8      = '0;
  logic          in_cin8    = 1'b0;
  logic          out_ready8 = 1'b0;
  logic          in_ready8;
  logic          out_valid8;
  logic [7:0]    out_sum8;
  logic          out_cout8;
  logic          busy8;

  rca_seq_ctrl #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
  );

  rca_seq_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_b(in_b8), .in_cin(in_cin8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_sum(out_sum8), .out_cout(out_cout8), .busy(busy8)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   rand_rdy  = 1'b0;
  bit   fixed_rdy = 1'b1;

  // Edge counter: after posedge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: drives out_ready shortly after each edge, random or fixed.
  always @(posedge clk) begin
    #2;
    out_ready = rand_rdy ? 1'($urandom) : fixed_rdy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: records accepted operands as expected results, checks presented results.
  initial begin : monitor
    logic       prev;
    logic [W:0] full;
    exp_t       e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        prev = 1'b0;
      end else begin
        if (out_valid) begin
          if (q.size() == 0) begin
            check("unexpected_output", 32'd1, 32'd0);
          end else begin
            if (!prev) check("latency", 32'(cyc - q[0].acc), 32'(NS));
            check("sum", 32'(out_sum), 32'(q[0].sum));
            check("cout", 32'(out_cout), 32'(q[0].cout));
            check("in_ready_while_valid", 32'(in_ready), 32'd0);
            if (out_ready) void'(q.pop_front());
          end
        end
        if (in_valid && in_ready) begin
          full  = {1'b0, in_a} + {1'b0, in_b} + (W+1)'(in_cin);
          e.sum  = full[W-1:0];
          e.cout = full[W];
          e.acc  = cyc + 1;
          q.push_back(e);
        end
        prev = out_valid && !out_ready;
      end
    end
  end

  // Offer one operand set; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit hold);
    bit took;
    int n;
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    n = 0;
    took = 1'b0;
    do begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!took && n < 200);
    if (!took) check("accept_timeout", 32'd0, 32'd1);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", 32'(n < 200), 32'd1);
  endtask

  // Directed and random stimulus.
  initial begin : stim
    int n;
    int a1, a2;
    logic [W-1:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_cout", 32'(out_cout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_idle();
    send(16'h1234, 16'h4321, 1'b1, 1'b0);
    wait_idle();

    // Backpressure in DONE with new operands offered.
    fixed_rdy = 1'b0;
    @(posedge clk);
    #1;
    send(16'hABCD, 16'h1111, 1'b0, 1'b0);
    in_a = 16'h5555; in_b = 16'h7777; in_cin = 1'b1; in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", 32'(out_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid_held", 32'(out_valid), 32'd1);
      check("bp_busy", 32'(busy), 32'd1);
    end
    in_valid  = 1'b0;
    fixed_rdy = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid && n < 20);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Reset while RUN is at idx 2.
    send(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_sum", 32'(out_sum), 32'd0);
    check("midrst_out_cout", 32'(out_cout), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    repeat (6) begin
      @(negedge clk);
      check("midrst_no_emit", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Back-to-back with in_valid held high.
    send(16'h00FF, 16'h0001, 1'b0, 1'b1);
    a1 = cyc;
    send(16'h8000, 16'h8000, 1'b0, 1'b1);
    a2 = cyc;
    in_valid = 1'b0;
    check("b2b_interval", 32'(a2 - a1), 32'd6);
    wait_idle();

    // Random traffic with random consumer stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = '1;
        1:       ra = '0;
        default: ra = W'($urandom);
      endcase
      rb = W'($urandom);
      send(ra, rb, 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle();
    rand_rdy  = 1'b0;
    fixed_rdy = 1'b1;

    // WIDTH=8 instance: 0xFF + 0xFF + 1.
    check("w8_in_ready", 32'(in_ready8), 32'd1);
    in_a8 = 8'hFF; in_b8 = 8'hFF; in_cin8 = 1'b1; in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("w8_latency", 32'(n), 32'd2);
    check("w8_sum", 32'(out_sum8), 32'hFF);
    check("w8_cout", 32'(out_cout8), 32'd1);
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    check("w8_consumed", 32'(out_valid8), 32'd0);
    check("w8_idle", 32'(in_ready8), 32'd1);

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
